// File: rtl/uart_fifo_ctrl_pkg.sv
// Shared constants for the buffered UART sequencer: CSR status bit positions,
// command bit positions and the TX handshake state type.
package uart_fifo_ctrl_pkg;

  localparam int UART_CSR_TXFULL_BIT = 31;
  localparam int UART_CSR_RXNE_BIT   = 30;
  localparam int UART_CSR_RXOVF_BIT  = 29;
  localparam int UART_CSR_TXIDLE_BIT = 28;
  localparam int UART_CSR_TXDROP_BIT = 27;
  localparam int UART_CSR_FRMERR_BIT = 26;

  localparam int UART_CMD_FLAG_BIT  = 31;
  localparam int UART_CMD_POP_BIT   = 0;
  localparam int UART_CMD_CLEAR_BIT = 1;
  localparam int UART_CMD_FLUSH_BIT = 2;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SEND,
    TX_WAIT_BUSY,
    TX_WAIT_DONE
  } uart_tx_state_t;

endpackage

// File: rtl/uart_fifo_ctrl_sync_fifo.sv
// Single-clock FIFO with flush; push while full is accepted only alongside a pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       din,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [WIDTH-1:0]       head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  // Flush wins over any push or pop landing in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_fifo_ctrl.sv
// Buffered UART sequencer: TX/RX FIFOs behind one CSR word, plus the
// send/send_busy handshake towards uart_controller.
module uart_fifo_ctrl
  import uart_fifo_ctrl_pkg::*;
#(
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_we,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic [7:0]  uart_send_data,
  output logic        uart_send,
  input  logic        uart_send_busy,
  input  logic [7:0]  uart_rev_data,
  input  logic        uart_rev_data_valid,
  input  logic        uart_rev_data_invalid
);

  uart_tx_state_t state;

  logic                      tx_full, tx_empty, rx_full, rx_empty;
  logic [$clog2(TX_DEPTH):0] tx_count;
  logic [$clog2(RX_DEPTH):0] rx_count;
  logic [7:0]                tx_head, rx_head;

  logic rx_valid_q, rx_invalid_q;
  logic rx_ovf, tx_drop, frm_err;

  logic is_cmd, tx_push, tx_pop, rx_pop, rx_edge, frm_edge;
  logic sticky_clear, flush;
  logic unused_bits;

  assign is_cmd       = csr_we && csr_wdata[UART_CMD_FLAG_BIT];
  assign tx_push      = csr_we && !csr_wdata[UART_CMD_FLAG_BIT];
  assign rx_pop       = is_cmd && csr_wdata[UART_CMD_POP_BIT];
  assign sticky_clear = is_cmd && csr_wdata[UART_CMD_CLEAR_BIT];
  assign flush        = is_cmd && csr_wdata[UART_CMD_FLUSH_BIT];
  assign rx_edge      = uart_rev_data_valid && !rx_valid_q;
  assign frm_edge     = uart_rev_data_invalid && !rx_invalid_q;
  assign tx_pop       = (state == TX_IDLE) && !tx_empty && !flush;
  assign unused_bits  = ^{csr_wdata[30:8], tx_count};

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .pop   (tx_pop),
    .flush (flush),
    .din   (csr_wdata[7:0]),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count),
    .head  (tx_head)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_edge),
    .pop   (rx_pop),
    .flush (flush),
    .din   (uart_rev_data),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count),
    .head  (rx_head)
  );

  // A full FIFO still accepts a byte when a pop frees a slot in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_valid_q   <= 1'b0;
      rx_invalid_q <= 1'b0;
      rx_ovf       <= 1'b0;
      tx_drop      <= 1'b0;
      frm_err      <= 1'b0;
    end else begin
      rx_valid_q   <= uart_rev_data_valid;
      rx_invalid_q <= uart_rev_data_invalid;
      if (sticky_clear) begin
        rx_ovf  <= 1'b0;
        tx_drop <= 1'b0;
        frm_err <= 1'b0;
      end else begin
        if (rx_edge && rx_full && !rx_pop)  rx_ovf  <= 1'b1;
        if (tx_push && tx_full && !tx_pop)  tx_drop <= 1'b1;
        if (frm_edge)                       frm_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= TX_IDLE;
      uart_send      <= 1'b0;
      uart_send_data <= '0;
    end else begin
      case (state)
        TX_IDLE: begin
          uart_send <= 1'b0;
          if (tx_pop) begin
            uart_send_data <= tx_head;
            uart_send      <= 1'b1;
            state          <= TX_SEND;
          end
        end
        TX_SEND: begin
          uart_send <= 1'b0;
          state     <= TX_WAIT_BUSY;
        end
        TX_WAIT_BUSY: begin
          uart_send <= 1'b0;
          if (uart_send_busy) state <= TX_WAIT_DONE;
        end
        TX_WAIT_DONE: begin
          uart_send <= 1'b0;
          if (!uart_send_busy) state <= TX_IDLE;
        end
        default: begin
          uart_send <= 1'b0;
          state     <= TX_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    csr_rdata                      = '0;
    csr_rdata[UART_CSR_TXFULL_BIT] = tx_full;
    csr_rdata[UART_CSR_RXNE_BIT]   = !rx_empty;
    csr_rdata[UART_CSR_RXOVF_BIT]  = rx_ovf;
    csr_rdata[UART_CSR_TXIDLE_BIT] = tx_empty && (state == TX_IDLE);
    csr_rdata[UART_CSR_TXDROP_BIT] = tx_drop;
    csr_rdata[UART_CSR_FRMERR_BIT] = frm_err;
    csr_rdata[23:16]               = 8'(rx_count);
    csr_rdata[7:0]                 = rx_head;
  end

endmodule
